snn_column_wta: RTL and testbench
=================================

Name: snn_column_wta

Overview:
- Parametrised successor of the fixed 4x4 column: NUM_INPUTS x NUM_NEURONS array of WRES-bit synapses feeding ramp-integrate neurons, with optional 1-winner-take-all lateral inhibition.
- Stochastic STDP is applied once per gamma cycle, on grst, gated by per-synapse BRV inputs.
- Adds a programmable threshold, a learn enable, a WTA enable, a winner index output and weight readback.
- Sits as the compute column under the top-level network, between the input encoder and the next layer.

Parameters:
- NUM_INPUTS, 8, input lines per column.
- NUM_NEURONS, 4, neurons per column.
- WRES, 3, weight bits; weight range 0..2^WRES-1.
- POT_W, 6, body-potential and threshold width.
- NUM_SYNAPSE, NUM_INPUTS*NUM_NEURONS, derived; synapse s = j*NUM_INPUTS+i (neuron j, input i).

Ports:
- clk  in  1  clock.
- rstb  in  1  synchronous active-low reset.
- grst  in  1  gamma reset; synchronous, active-high, one-cycle pulse.
- input_spikes  in  NUM_INPUTS  step spikes; held high until grst.
- w_init  in  NUM_SYNAPSE*WRES  weights loaded during reset.
- threshold  in  POT_W  firing threshold.
- learn_en  in  1  enables STDP on grst.
- wta_en  in  1  enables 1-WTA.
- num_inputs  in  clog2(NUM_INPUTS)  active inputs minus 1.
- num_neurons  in  clog2(NUM_NEURONS)  active neurons minus 1.
- capture_brv, minus_brv, search_brv, backoff_brv  in  NUM_SYNAPSE each  per-synapse BRVs.
- output_spikes  out  NUM_NEURONS  fired flags; held until grst.
- winner_idx  out  clog2(NUM_NEURONS)  first neuron to fire.
- winner_valid  out  1  winner_idx meaningful.
- weights  out  NUM_SYNAPSE*WRES  current weights.

Behaviour:
- Priority at each edge: rstb low, then grst, then integration.
- rstb low (synchronous):
  - weights <= w_init.
  - All pot, fired, cap and seen flags cleared.
  - output_spikes=0, winner_idx=0, winner_valid=0.
  - grst is ignored.
- Masking: input i is active iff i <= num_inputs; neuron j is enabled iff j <= num_neurons. Masked inputs contribute nothing and count as never seen. Disabled neurons never fire and their weights never change.
- Integration, every edge with rstb=1 and grst=0:
  - pot_next[j] = pot[j] + sum of w[j][i] over active inputs with input_spikes[i]=1.
  - pot_next saturates at 2^POT_W-1. pot stops updating once neuron j has fired.
  - seen[i] <= seen[i] | input_spikes[i].
- Fire condition for an unfired, enabled neuron: pot_next[j] >= threshold and pot_next[j] != 0. threshold=0 therefore fires on the first nonzero input.
  - Single-cycle latency: fired[j] and output_spikes[j] go high after the same edge that pot_next crosses.
- WTA, when wta_en=1:
  - No neuron may fire once any fired flag is set.
  - If several neurons qualify on the same edge, only the lowest index fires.
- WTA, when wta_en=0: every qualifying neuron fires.
- Winner: on the first firing edge, winner_idx <= lowest firing index and winner_valid <= 1. Both hold until grst.
- Capture snapshot: when neuron j fires, cap[j][i] <= input_spikes[i] (masked), taken at the firing edge.
- grst edge:
  - If learn_en=1, each synapse of an enabled neuron gets exactly one case (first match wins):
    - fired[j] & cap -> capture: +1 if capture_brv.
    - fired[j] & seen[i] & ~cap -> minus: -1 if minus_brv.
    - fired[j] & ~seen[i] -> backoff: -1 if backoff_brv.
    - ~fired[j] & seen[i] -> search: +1 if search_brv.
    - Neither fired nor seen -> hold.
  - Weights saturate at 0 and 2^WRES-1; no wrap-around.
  - All pot, fired, cap and seen state, output_spikes and winner_valid are cleared at the same edge.
  - Inputs sampled during the grst edge are discarded.
- A grst held high for several cycles applies STDP once per high edge; the second edge sees cleared flags, so its learning case is hold or search only via new seen bits (which stay clear).
- Changing num_inputs, num_neurons, threshold or wta_en mid-gamma takes effect at the next edge; already-set fired flags are kept.

Decomposition:
- Shared package snn_pkg:
  - stdp_case_e enum {STDP_HOLD, STDP_CAPTURE, STDP_MINUS, STDP_BACKOFF, STDP_SEARCH}.
  - Saturating-add helper function.
  - Default WRES/POT_W constants.
- Sub-module snn_synapse (one per synapse): weight register, reset load, case decode from fired/cap/seen, BRV-gated saturating +/-1.
- Column level owns potentials, fire logic, WTA priority encoder and winner registers.

Test Plan:
- Reset load: rstb=0 with w_init all 4, then rstb=1 -> weights all 4, output_spikes=0, winner_valid=0.
- Latency: threshold=8, w=4, NUM_INPUTS=8, only input0 high from edge E0 -> pot 4 after E0; output_spikes[0..3] high after E1; winner_idx=0, winner_valid=1.
- WTA tie and ordering, wta_en=1:
  - Neurons 1 and 2 reach threshold on the same edge -> only output_spikes[1] high; neuron 2 stays low for the rest of the gamma.
  - Repeat with wta_en=0 -> both high.
- STDP cases, all BRVs=1, learn_en=1, w=4:
  - Inputs 0 and 1 high before the fire edge -> capture -> 5.
  - Input 2 rises after the fire edge -> minus -> 3.
  - Input 3 never high -> backoff -> 3.
  - Unfired neuron with input 0 seen -> search -> 5.
  - Repeat with learn_en=0 -> all remain 4.
- Saturation and masking:
  - w=7 under repeated capture -> stays 7; w=0 under backoff -> stays 0.
  - num_inputs=1: input 5 high contributes nothing and its weight is unchanged.
  - num_neurons=1: neurons 2 and 3 never fire.
- Reset mid-gamma: rstb=0 while neuron 0 has fired and grst=1 is asserted on the same edge -> no STDP applied, weights = w_init, all outputs 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking column: STDP case labels,
// default widths and a saturating adder used for potentials and weights.
package snn_pkg;

    localparam int DEF_WRES  = 3;
    localparam int DEF_POT_W = 6;

    typedef enum logic [2:0] {
        STDP_HOLD,
        STDP_CAPTURE,
        STDP_MINUS,
        STDP_BACKOFF,
        STDP_SEARCH
    } stdp_case_e;

    // Unsigned a+b clamped to max_val; the 33-bit sum cannot overflow.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_val}) ? max_val : s[31:0];
    endfunction

endpackage

// File: rtl/snn_column_wta_if.sv
// Control, spike and weight bus of one column. The driver of stimulus and
// configuration uses the master view, the column uses the slave view.
interface snn_column_wta_if #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 4,
    parameter int WRES        = 3,
    parameter int POT_W       = 6
);
    localparam int NUM_SYNAPSE = NUM_INPUTS * NUM_NEURONS;
    localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                        grst;
    logic [NUM_INPUTS-1:0]       input_spikes;
    logic [NUM_SYNAPSE*WRES-1:0] w_init;
    logic [POT_W-1:0]            threshold;
    logic                        learn_en;
    logic                        wta_en;
    logic [IW-1:0]               num_inputs;
    logic [NW-1:0]               num_neurons;
    logic [NUM_SYNAPSE-1:0]      capture_brv;
    logic [NUM_SYNAPSE-1:0]      minus_brv;
    logic [NUM_SYNAPSE-1:0]      search_brv;
    logic [NUM_SYNAPSE-1:0]      backoff_brv;
    logic [NUM_NEURONS-1:0]      output_spikes;
    logic [NW-1:0]               winner_idx;
    logic                        winner_valid;
    logic [NUM_SYNAPSE*WRES-1:0] weights;

    modport master (
        output grst, input_spikes, w_init, threshold, learn_en, wta_en,
               num_inputs, num_neurons, capture_brv, minus_brv, search_brv, backoff_brv,
        input  output_spikes, winner_idx, winner_valid, weights
    );

    modport slave (
        input  grst, input_spikes, w_init, threshold, learn_en, wta_en,
               num_inputs, num_neurons, capture_brv, minus_brv, search_brv, backoff_brv,
        output output_spikes, winner_idx, winner_valid, weights
    );

endinterface

// File: rtl/snn_synapse.sv
// One plastic synapse: weight register loaded at reset and nudged by one
// step on each gamma reset according to the neuron's fire/capture/seen state.
module snn_synapse
    import snn_pkg::*;
#(
    parameter int WRES = DEF_WRES
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            grst,
    input  logic            learn_en,
    input  logic            neuron_en,
    input  logic            fired,
    input  logic            cap,
    input  logic            seen,
    input  logic            capture_brv,
    input  logic            minus_brv,
    input  logic            search_brv,
    input  logic            backoff_brv,
    input  logic [WRES-1:0] w_init,
    output logic [WRES-1:0] weight
);
    localparam logic [WRES-1:0] W_MAX = '1;

    stdp_case_e      stdp_case;
    logic [WRES-1:0] weight_reg;
    logic [WRES-1:0] weight_next;

    // Classify this synapse; earlier branches take precedence.
    always_comb begin
        stdp_case = STDP_HOLD;
        if (fired && cap)       stdp_case = STDP_CAPTURE;
        else if (fired && seen) stdp_case = STDP_MINUS;
        else if (fired)         stdp_case = STDP_BACKOFF;
        else if (seen)          stdp_case = STDP_SEARCH;
    end

    // BRV-gated +/-1 step, clamped at both ends of the weight range.
    always_comb begin
        weight_next = weight_reg;
        if (learn_en && neuron_en) begin
            case (stdp_case)
                STDP_CAPTURE: if (capture_brv && weight_reg != W_MAX) weight_next = weight_reg + WRES'(1);
                STDP_SEARCH:  if (search_brv  && weight_reg != W_MAX) weight_next = weight_reg + WRES'(1);
                STDP_MINUS:   if (minus_brv   && weight_reg != '0)    weight_next = weight_reg - WRES'(1);
                STDP_BACKOFF: if (backoff_brv && weight_reg != '0)    weight_next = weight_reg - WRES'(1);
                default:      weight_next = weight_reg;
            endcase
        end
    end

    // Reset load has priority; learning only happens on gamma reset edges.
    always_ff @(posedge clk) begin
        if (!rstb)     weight_reg <= w_init;
        else if (grst) weight_reg <= weight_next;
    end

    assign weight = weight_reg;

endmodule

// File: rtl/snn_column_wta.sv
// Column of ramp-integrate neurons over a synapse array with optional
// 1-winner-take-all, winner reporting and per-gamma stochastic STDP.
module snn_column_wta
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 4,
    parameter int WRES        = DEF_WRES,
    parameter int POT_W       = DEF_POT_W
) (
    input logic               clk,
    input logic               rstb,
    snn_column_wta_if.slave   bus
);
    localparam int NUM_SYNAPSE = NUM_INPUTS * NUM_NEURONS;
    localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [31:0] POT_MAX = 32'((1 << POT_W) - 1);

    logic [POT_W-1:0]            pot_reg  [NUM_NEURONS];
    logic [POT_W-1:0]            pot_next [NUM_NEURONS];
    logic [NUM_INPUTS-1:0]       cap_reg  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]      fired_reg;
    logic [NUM_NEURONS-1:0]      qualify;
    logic [NUM_NEURONS-1:0]      fire_vec;
    logic [NUM_NEURONS-1:0]      neuron_en;
    logic [NUM_INPUTS-1:0]       seen_reg;
    logic [NUM_INPUTS-1:0]       input_active;
    logic [NUM_INPUTS-1:0]       spikes_active;
    logic [NW-1:0]               winner_idx_reg;
    logic [NW-1:0]               winner_idx_next;
    logic                        winner_valid_reg;
    logic                        found;
    logic [WRES-1:0]             w [NUM_SYNAPSE];
    logic [NUM_SYNAPSE*WRES-1:0] weights_flat;

    genvar gi;

    // Input and neuron enable masks from the active-count controls.
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in_mask
        assign input_active[gi] = (IW'(gi) <= bus.num_inputs);
    end
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_nrn_mask
        assign neuron_en[gi] = (NW'(gi) <= bus.num_neurons);
    end
    assign spikes_active = bus.input_spikes & input_active;

    // Per-neuron saturating integration and threshold test.
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_integ
        logic [31:0] acc;
        always_comb begin
            acc = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (spikes_active[i]) acc = acc + 32'(w[gi*NUM_INPUTS+i]);
            end
            pot_next[gi] = POT_W'(sat_add(32'(pot_reg[gi]), acc, POT_MAX));
            qualify[gi]  = neuron_en[gi] && !fired_reg[gi] &&
                           (pot_next[gi] >= bus.threshold) && (pot_next[gi] != '0);
        end
    end

    // WTA priority: lowest qualifying index wins; nobody fires after a winner.
    always_comb begin
        fire_vec        = '0;
        winner_idx_next = '0;
        found           = 1'b0;
        for (int j = 0; j < NUM_NEURONS; j++) begin
            if (qualify[j]) begin
                if (!bus.wta_en || (fired_reg == '0 && !found)) fire_vec[j] = 1'b1;
                if (!found) winner_idx_next = NW'(j);
                found = 1'b1;
            end
        end
    end

    // Column state: reset, gamma clear, or integrate/fire/record.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int j = 0; j < NUM_NEURONS; j++) begin
                pot_reg[j] <= '0;
                cap_reg[j] <= '0;
            end
            fired_reg        <= '0;
            seen_reg         <= '0;
            winner_idx_reg   <= '0;
            winner_valid_reg <= 1'b0;
        end else if (bus.grst) begin
            for (int j = 0; j < NUM_NEURONS; j++) begin
                pot_reg[j] <= '0;
                cap_reg[j] <= '0;
            end
            fired_reg        <= '0;
            seen_reg         <= '0;
            winner_valid_reg <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_NEURONS; j++) begin
                if (!fired_reg[j]) pot_reg[j] <= pot_next[j];
                if (fire_vec[j])   cap_reg[j] <= spikes_active;
            end
            fired_reg <= fired_reg | fire_vec;
            seen_reg  <= seen_reg | spikes_active;
            if (!winner_valid_reg && fire_vec != '0) begin
                winner_idx_reg   <= winner_idx_next;
                winner_valid_reg <= 1'b1;
            end
        end
    end

    // Synapse array, s = j*NUM_INPUTS + i; masked inputs look unseen/uncaptured.
    for (gi = 0; gi < NUM_SYNAPSE; gi++) begin : g_syn
        snn_synapse #(.WRES(WRES)) u_syn (
            .clk        (clk),
            .rstb       (rstb),
            .grst       (bus.grst),
            .learn_en   (bus.learn_en),
            .neuron_en  (neuron_en[gi/NUM_INPUTS]),
            .fired      (fired_reg[gi/NUM_INPUTS]),
            .cap        (cap_reg[gi/NUM_INPUTS][gi%NUM_INPUTS] & input_active[gi%NUM_INPUTS]),
            .seen       (seen_reg[gi%NUM_INPUTS] & input_active[gi%NUM_INPUTS]),
            .capture_brv(bus.capture_brv[gi]),
            .minus_brv  (bus.minus_brv[gi]),
            .search_brv (bus.search_brv[gi]),
            .backoff_brv(bus.backoff_brv[gi]),
            .w_init     (bus.w_init[gi*WRES +: WRES]),
            .weight     (w[gi])
        );
        assign weights_flat[gi*WRES +: WRES] = w[gi];
    end

    assign bus.output_spikes = fired_reg;
    assign bus.winner_idx    = winner_idx_reg;
    assign bus.winner_valid  = winner_valid_reg;
    assign bus.weights       = weights_flat;

endmodule

// File: tb/tb_snn_column_wta.sv
// Directed and random checks of the column against a gamma-level reference model.
module tb_snn_column_wta;
    localparam int NI = 8;
    localparam int NN = 4;
    localparam int WRES = 3;
    localparam int POT_W = 6;
    localparam int NS = NI * NN;
    localparam int WMAX = (1 << WRES) - 1;
    localparam int PMAX = (1 << POT_W) - 1;

    logic clk = 1'b0;
    logic rstb;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    snn_column_wta_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .WRES(WRES), .POT_W(POT_W)) bus ();

    snn_column_wta #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .WRES(WRES), .POT_W(POT_W)) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    // reference model state
    int m_w [NS];
    int m_pot [NN];
    bit m_fired [NN];
    bit m_cap [NN][NI];
    bit m_seen [NI];
    int m_win;
    bit m_wv;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dut_w(input int s);
        return int'(bus.weights[s*WRES +: WRES]);
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NN; j++) begin
            m_pot[j] = 0;
            m_fired[j] = 0;
            for (int i = 0; i < NI; i++) m_cap[j][i] = 0;
        end
        for (int i = 0; i < NI; i++) m_seen[i] = 0;
        m_wv = 0;
    endtask

    // One clock edge of the column, applied from the rules directly.
    task automatic model_edge();
        int ni, nn, s, sum;
        bit act [NI];
        int pn [NN];
        bit q [NN];
        bit any_f, first_taken, sn, cp;
        ni = int'(bus.num_inputs);
        nn = int'(bus.num_neurons);
        for (int i = 0; i < NI; i++) act[i] = (i <= ni) && bus.input_spikes[i];
        if (!rstb) begin
            for (int k = 0; k < NS; k++) m_w[k] = int'(bus.w_init[k*WRES +: WRES]);
            model_clear();
            m_win = 0;
        end else if (bus.grst) begin
            if (bus.learn_en) begin
                for (int j = 0; j <= nn; j++) begin
                    for (int i = 0; i < NI; i++) begin
                        s  = j * NI + i;
                        sn = m_seen[i] && (i <= ni);
                        cp = m_cap[j][i] && (i <= ni);
                        if (m_fired[j] && cp) begin
                            if (bus.capture_brv[s] && m_w[s] < WMAX) m_w[s]++;
                        end else if (m_fired[j] && sn) begin
                            if (bus.minus_brv[s] && m_w[s] > 0) m_w[s]--;
                        end else if (m_fired[j]) begin
                            if (bus.backoff_brv[s] && m_w[s] > 0) m_w[s]--;
                        end else if (sn) begin
                            if (bus.search_brv[s] && m_w[s] < WMAX) m_w[s]++;
                        end
                    end
                end
            end
            model_clear();
        end else begin
            any_f = 0;
            for (int j = 0; j < NN; j++) any_f |= m_fired[j];
            for (int j = 0; j < NN; j++) begin
                sum = 0;
                for (int i = 0; i < NI; i++) if (act[i]) sum += m_w[j*NI+i];
                pn[j] = (m_pot[j] + sum > PMAX) ? PMAX : m_pot[j] + sum;
                q[j] = (j <= nn) && !m_fired[j] && (pn[j] >= int'(bus.threshold)) && (pn[j] != 0);
            end
            for (int j = 0; j < NN; j++) if (!m_fired[j]) m_pot[j] = pn[j];
            first_taken = 0;
            for (int j = 0; j < NN; j++) begin
                if (q[j]) begin
                    if (!bus.wta_en || (!any_f && !first_taken)) begin
                        m_fired[j] = 1;
                        for (int i = 0; i < NI; i++) m_cap[j][i] = act[i];
                        if (!m_wv) begin
                            m_win = j;
                            m_wv = 1;
                        end
                    end
                    first_taken = 1;
                end
            end
            for (int i = 0; i < NI; i++) m_seen[i] |= act[i];
        end
    endtask

    task automatic check_all(input string tag);
        logic [NN-1:0] es;
        logic [NS*WRES-1:0] ew;
        for (int j = 0; j < NN; j++) es[j] = m_fired[j];
        for (int k = 0; k < NS; k++) ew[k*WRES +: WRES] = WRES'(m_w[k]);
        chk({tag, "/spikes"}, 128'(bus.output_spikes), 128'(es));
        chk({tag, "/wvalid"}, 128'(bus.winner_valid), 128'(m_wv));
        if (m_wv) chk({tag, "/widx"}, 128'(bus.winner_idx), 128'(m_win));
        chk({tag, "/weights"}, 128'(bus.weights), 128'(ew));
        $display("txn %s t=%0t spikes=%b wv=%b widx=%0d", tag, $time, bus.output_spikes, bus.winner_valid, bus.winner_idx);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_w(input int v);
        for (int k = 0; k < NS; k++) bus.w_init[k*WRES +: WRES] = WRES'(v);
    endtask

    task automatic do_reset(input string tag);
        rstb = 1'b0;
        cyc(tag);
        rstb = 1'b1;
    endtask

    task automatic gamma_end(input string tag);
        bus.grst = 1'b1;
        bus.input_spikes = '0;
        cyc(tag);
        bus.grst = 1'b0;
    endtask

    initial begin
        logic [NS*WRES-1:0] all4;
        rstb = 1'b0;
        bus.grst = 1'b0;
        bus.input_spikes = '0;
        bus.threshold = 6'd8;
        bus.learn_en = 1'b1;
        bus.wta_en = 1'b1;
        bus.num_inputs = 3'd7;
        bus.num_neurons = 2'd3;
        bus.capture_brv = '1;
        bus.minus_brv = '1;
        bus.search_brv = '1;
        bus.backoff_brv = '1;
        set_w(4);
        for (int k = 0; k < NS; k++) all4[k*WRES +: WRES] = 3'd4;

        // reset load
        do_reset("reset");
        chk("reset_weights", 128'(bus.weights), 128'(all4));
        chk("reset_spikes", 128'(bus.output_spikes), 128'(0));
        chk("reset_wvalid", 128'(bus.winner_valid), 128'(0));

        // single-cycle latency, all neurons fire with WTA off
        bus.wta_en = 1'b0;
        bus.learn_en = 1'b0;
        bus.input_spikes = 8'h01;
        cyc("lat_e0");
        chk("lat_e0_spikes", 128'(bus.output_spikes), 128'(0));
        cyc("lat_e1");
        chk("lat_e1_spikes", 128'(bus.output_spikes), 128'(4'hF));
        chk("lat_e1_widx", 128'(bus.winner_idx), 128'(0));
        chk("lat_e1_wvalid", 128'(bus.winner_valid), 128'(1));
        gamma_end("lat_grst");
        chk("lat_nolearn", 128'(bus.weights), 128'(all4));

        // WTA tie between neurons 1 and 2
        for (int k = 0; k < NS; k++) bus.w_init[k*WRES +: WRES] = (k / NI == 1 || k / NI == 2) ? 3'd4 : 3'd1;
        do_reset("tie_reset");
        bus.wta_en = 1'b1;
        bus.input_spikes = 8'h01;
        for (int c = 0; c < 10; c++) cyc("tie_wta");
        chk("tie_wta_spikes", 128'(bus.output_spikes), 128'(4'b0010));
        chk("tie_wta_widx", 128'(bus.winner_idx), 128'(1));
        gamma_end("tie_grst");
        bus.wta_en = 1'b0;
        bus.input_spikes = 8'h01;
        cyc("tie_nowta1");
        cyc("tie_nowta2");
        chk("tie_nowta_spikes", 128'(bus.output_spikes), 128'(4'b0110));
        gamma_end("tie_grst2");

        // STDP cases with learning on, then off
        for (int pass = 0; pass < 2; pass++) begin
            set_w(4);
            bus.learn_en = (pass == 0);
            bus.wta_en = 1'b1;
            bus.threshold = 6'd8;
            do_reset("stdp_reset");
            bus.input_spikes = 8'h03;
            cyc("stdp_fire");
            bus.input_spikes = 8'h07;
            cyc("stdp_late");
            gamma_end("stdp_grst");
            if (pass == 0) begin
                chk("stdp_capture", 128'(dut_w(0)), 128'(5));
                chk("stdp_minus", 128'(dut_w(2)), 128'(3));
                chk("stdp_backoff", 128'(dut_w(3)), 128'(3));
                chk("stdp_search", 128'(dut_w(NI)), 128'(5));
                chk("stdp_hold", 128'(dut_w(NI + 3)), 128'(4));
            end else begin
                chk("stdp_off", 128'(bus.weights), 128'(all4));
            end
        end

        // saturation at both ends
        bus.learn_en = 1'b1;
        set_w(0);
        bus.w_init[2:0] = 3'd7;
        bus.threshold = 6'd7;
        do_reset("sat_reset");
        for (int g = 0; g < 2; g++) begin
            bus.input_spikes = 8'h01;
            cyc("sat_fire");
            gamma_end("sat_grst");
        end
        chk("sat_top", 128'(dut_w(0)), 128'(7));
        chk("sat_bottom", 128'(dut_w(1)), 128'(0));

        // input masking
        set_w(4);
        bus.threshold = 6'd8;
        bus.num_inputs = 3'd1;
        do_reset("mask_in_reset");
        bus.input_spikes = 8'h21;
        cyc("mask_in");
        chk("mask_in_nofire", 128'(bus.output_spikes), 128'(0));
        gamma_end("mask_in_grst");
        chk("mask_in_w5", 128'(dut_w(5)), 128'(4));
        chk("mask_in_w0", 128'(dut_w(0)), 128'(5));
        bus.num_inputs = 3'd7;

        // neuron masking
        set_w(4);
        bus.num_neurons = 2'd1;
        bus.wta_en = 1'b0;
        bus.threshold = 6'd4;
        do_reset("mask_n_reset");
        bus.input_spikes = 8'h01;
        cyc("mask_n");
        cyc("mask_n2");
        chk("mask_n_spikes", 128'(bus.output_spikes), 128'(4'b0011));
        gamma_end("mask_n_grst");
        chk("mask_n_hold", 128'(dut_w(2 * NI)), 128'(4));
        bus.num_neurons = 2'd3;

        // reset beats gamma reset mid-gamma
        set_w(4);
        bus.wta_en = 1'b1;
        do_reset("midrst_reset");
        bus.input_spikes = 8'h01;
        cyc("midrst_fire");
        set_w(2);
        rstb = 1'b0;
        bus.grst = 1'b1;
        cyc("midrst");
        chk("midrst_w", 128'(dut_w(0)), 128'(2));
        chk("midrst_spikes", 128'(bus.output_spikes), 128'(0));
        chk("midrst_wvalid", 128'(bus.winner_valid), 128'(0));
        chk("midrst_widx", 128'(bus.winner_idx), 128'(0));
        rstb = 1'b1;
        bus.grst = 1'b0;
        bus.input_spikes = '0;

        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.capture_brv = NS'($urandom());
            bus.minus_brv = NS'($urandom());
            bus.search_brv = NS'($urandom());
            bus.backoff_brv = NS'($urandom());
            if ($urandom_range(0, 60) == 0) begin
                rstb = 1'b0;
                for (int k = 0; k < NS; k++) bus.w_init[k*WRES +: WRES] = WRES'($urandom());
            end else begin
                rstb = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.grst = 1'b1;
                bus.learn_en = 1'($urandom());
                bus.wta_en = 1'($urandom());
                bus.threshold = POT_W'($urandom_range(0, 40));
                bus.num_inputs = 3'($urandom());
                bus.num_neurons = 2'($urandom());
            end else begin
                if (bus.grst) bus.input_spikes = '0;
                bus.grst = 1'b0;
                if ($urandom_range(0, 2) == 0) bus.input_spikes = bus.input_spikes | NI'($urandom());
            end
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
